alu_unit: RTL and testbench

- Registered WIDTH-bit arithmetic/logic unit.
- A 4-bit opcode selects one of 16 operations on operands A and B; the result and a carry flag are registered on the rising clock edge.
- Sits behind the team's ALU interface bundle (A, B, ALU_Sel, ALU_Out, CarryOut) and is driven from a shared clock interface.

---
 rtl/alu_unit_if.sv | 27 ++
 rtl/alu_unit.sv | 85 ++++++++
 tb/tb_alu_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// ALU bus bundle: operands, opcode and the registered result/carry.
// The master drives A, B and ALU_Sel; the slave returns ALU_Out and CarryOut.
interface alu_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;

  modport master (
    output A,
    output B,
    output ALU_Sel,
    input  ALU_Out,
    input  CarryOut
  );

  modport slave (
    input  A,
    input  B,
    input  ALU_Sel,
    output ALU_Out,
    output CarryOut
  );
endinterface

// File: rtl/alu_unit.sv
// Registered WIDTH-bit ALU: 16 operations selected by a 4-bit opcode.
// Handshake: there is none. Every rising clk edge samples A/B/ALU_Sel and the
// result appears on ALU_Out/CarryOut after that edge, holding until the next.
// CarryOut is always the carry of A+B, whatever the opcode.
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_SHL  = 4'b0100,
    OP_SHR  = 4'b0101,
    OP_ROL  = 4'b0110,
    OP_ROR  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_NOR  = 4'b1011,
    OP_NAND = 4'b1100,
    OP_XNOR = 4'b1101,
    OP_GT   = 4'b1110,
    OP_EQ   = 4'b1111
  } alu_op_e;

  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             carry_d, carry_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_a, op_b;
  alu_op_e          op;

  assign op_a = bus.A;
  assign op_b = bus.B;
  assign op   = alu_op_e'(bus.ALU_Sel);

  // Shared (WIDTH+1)-bit adder: low bits feed ADD, the top bit is the carry flag.
  assign sum = {1'b0, op_a} + {1'b0, op_b};

  // Combinational datapath: select the result for the current opcode.
  always_comb begin
    alu_out_d = '0;
    carry_d   = sum[WIDTH];
    unique case (op)
      OP_ADD:  alu_out_d = sum[WIDTH-1:0];
      OP_SUB:  alu_out_d = op_a - op_b;
      OP_MUL:  alu_out_d = op_a * op_b;
      // Divide by zero saturates to all ones rather than relying on tool behaviour.
      OP_DIV:  alu_out_d = (op_b == '0) ? '1 : (op_a / op_b);
      OP_SHL:  alu_out_d = {op_a[WIDTH-2:0], 1'b0};
      OP_SHR:  alu_out_d = {1'b0, op_a[WIDTH-1:1]};
      OP_ROL:  alu_out_d = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
      OP_ROR:  alu_out_d = {op_a[0], op_a[WIDTH-1:1]};
      OP_AND:  alu_out_d = op_a & op_b;
      OP_OR:   alu_out_d = op_a | op_b;
      OP_XOR:  alu_out_d = op_a ^ op_b;
      OP_NOR:  alu_out_d = ~(op_a | op_b);
      OP_NAND: alu_out_d = ~(op_a & op_b);
      OP_XNOR: alu_out_d = ~(op_a ^ op_b);
      OP_GT:   alu_out_d = {{(WIDTH-1){1'b0}}, (op_a > op_b)};
      OP_EQ:   alu_out_d = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      default: alu_out_d = '0;
    endcase
  end

  // Output register stage; synchronous reset wins over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.ALU_Out  = alu_out_q;
  assign bus.CarryOut = carry_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed scenarios plus random traffic, checked against
// a scoreboard queue filled from an arithmetic reference model.
module tb_alu_unit;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [W:0] exp_q[$];

  alu_unit_if #(.WIDTH(W)) bus ();

  alu_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from integer arithmetic; returns {carry, result}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [3:0] sel);
    int unsigned ia;
    int unsigned ib;
    int unsigned s;
    logic [W-1:0] r;
    ia = a;
    ib = b;
    s  = ia + ib;
    case (sel)
      4'd0:  r = W'(s);
      4'd1:  r = W'(ia + 256 - ib);
      4'd2:  r = W'(ia * ib);
      4'd3:  r = (ib == 0) ? 8'hFF : W'(ia / ib);
      4'd4:  r = W'(ia * 2);
      4'd5:  r = W'(ia / 2);
      4'd6:  r = W'(ia * 2) | W'(ia / 128);
      4'd7:  r = W'(ia / 2) | W'((ia % 2) * 128);
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = (ia > ib) ? 8'h01 : 8'h00;
      default: r = (ia == ib) ? 8'h01 : 8'h00;
    endcase
    return {(s > 255), r};
  endfunction

  // Driver: apply one cycle of inputs, push the expectation, sample after the edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] sel, input logic r);
    bus.A       = a;
    bus.B       = b;
    bus.ALU_Sel = sel;
    rst         = r;
    exp_q.push_back(r ? '0 : model(a, b, sel));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [W:0] exp;
    logic [W:0] got;
    for (int i = 0; i < 2; i++) begin
      step(8'hFF, 8'hFF, 4'b0000, 1'b1);
      got = {bus.CarryOut, bus.ALU_Out};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1AA;
      total++;
      if (got !== exp || got !== 9'h000) begin
        bad++;
        $display("FAIL reset_%0d got=%h exp=%h", i, got, exp);
      end
    end
    step(8'hFF, 8'hFF, 4'b0000, 1'b0);
    got = {bus.CarryOut, bus.ALU_Out};
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0AA;
    total++;
    if (got !== exp || got !== 9'h1FE) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_and;
    logic [W-1:0] ta[2] = '{8'hF0, 8'h0F};
    logic [W-1:0] tb[2] = '{8'h3C, 8'h10};
    logic [W:0]   tl[2] = '{9'h130, 9'h000};
    logic [W:0] exp;
    logic [W:0] got;
    // Inputs held one extra cycle with a different value beforehand to show latency.
    step(8'h00, 8'h00, 4'b1001, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      bus.A = ta[i];
      bus.B = tb[i];
      bus.ALU_Sel = 4'b1000;
      #1;
      got = {bus.CarryOut, bus.ALU_Out};
      total++;
      if (got === tl[i]) begin
        bad++;
        $display("FAIL and_early_%0d got=%h before clock edge", i, got);
      end
      step(ta[i], tb[i], 4'b1000, 1'b0);
      got = {bus.CarryOut, bus.ALU_Out};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~tl[i];
      total++;
      if (got !== exp || got !== tl[i]) begin
        bad++;
        $display("FAIL and_%0d got=%h exp=%h", i, got, tl[i]);
      end
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[15] = '{8'h05, 8'h10, 8'h64, 8'h64, 8'h81, 8'h81, 8'h81, 8'h81,
                             8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h33, 8'hFF};
    logic [W-1:0] tb[15] = '{8'h07, 8'h10, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h33, 8'h01};
    logic [3:0]   ts[15] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                             4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd0};
    logic [W-1:0] tl[15] = '{8'hFE, 8'h00, 8'h0E, 8'hFF, 8'h02, 8'h40, 8'h03, 8'hC0,
                             8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    logic [W:0] exp;
    logic [W:0] got;
    for (int i = 0; i < 15; i++) begin
      step(ta[i], tb[i], ts[i], 1'b0);
      got = {bus.CarryOut, bus.ALU_Out};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~got;
      total++;
      if (got !== exp || got[W-1:0] !== tl[i]) begin
        bad++;
        $display("FAIL directed_%0d sel=%b got=%h exp=%h lit=%h", i, ts[i], got, exp, tl[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W:0] exp;
    logic [W:0] got;
    logic       r;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        r = (pass == 0 && i == 8);
        step(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 4'(i), r);
        got = {bus.CarryOut, bus.ALU_Out};
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~got;
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL b2b_p%0d_op%0d rst=%0d got=%h exp=%h", pass, i, r, got, exp);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [W:0] exp;
    logic [W:0] got;
    logic       r;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      step(W'($urandom_range(0, 255)), W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)),
           4'($urandom_range(0, 15)), r);
      got = {bus.CarryOut, bus.ALU_Out};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~got;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_%0d A=%h B=%h sel=%b rst=%0d got=%h exp=%h",
                 i, bus.A, bus.B, bus.ALU_Sel, r, got, exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_Sel = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_and();
    test_directed();
    test_back_to_back();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
